// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// the fetch FSM state encoding and small combinational helpers.
package instr_fetch_pkg;

    // Default datapath widths used across the core
    localparam int IF_ADDR_W_DEF  = 64;
    localparam int IF_INSTR_W_DEF = 32;

    // Fetch FSM states; at most one memory request is ever in flight
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // no request; latches the PC on the next edge
        ST_WAIT  = 2'd1,  // request outstanding, response wanted
        ST_HOLD  = 2'd2,  // response parked in the skid register
        ST_DRAIN = 2'd3   // request outstanding, response to be thrown away
    } fetch_state_t;

    // The IF/ID buffer can take a new instruction this cycle
    function automatic logic buf_free(input logic valid, input logic ready);
        return (~valid) | ready;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one fetch at a time, fills the IF/ID
// buffer, parks a response in a skid register under decode backpressure,
// and drains or drops responses that a redirect has made stale.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W  = IF_ADDR_W_DEF,
    parameter int INSTR_W = IF_INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               flush,
    input  logic               id_ready,
    input  logic               iresp_data_ok,
    input  logic [INSTR_W-1:0] iresp_data,
    output logic               ireq_valid,
    output logic [ADDR_W-1:0]  ireq_addr,
    output logic               pc_stall,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr
);

    fetch_state_t       state_r,    state_nxt_s;
    logic [ADDR_W-1:0]  req_addr_r, req_addr_nxt_s;
    logic [INSTR_W-1:0] skid_r,     skid_nxt_s;
    logic               if_valid_r, if_valid_nxt_s;
    logic [ADDR_W-1:0]  if_pc_r,    if_pc_nxt_s;
    logic [INSTR_W-1:0] if_instr_r, if_instr_nxt_s;
    logic               ireq_valid_s;
    logic               pc_stall_s;

    // Next-state, buffer update and request/stall decode for the fetch FSM
    always_comb begin
        state_nxt_s    = state_r;
        req_addr_nxt_s = req_addr_r;
        skid_nxt_s     = skid_r;
        // A consumed buffer empties unless a branch below reloads it
        if_valid_nxt_s = if_valid_r & ~id_ready;
        if_pc_nxt_s    = if_pc_r;
        if_instr_nxt_s = if_instr_r;
        ireq_valid_s   = 1'b0;
        pc_stall_s     = 1'b1;

        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    // PC takes the redirect now; fetch from it next cycle
                    pc_stall_s     = 1'b0;
                    if_valid_nxt_s = 1'b0;
                    skid_nxt_s     = {INSTR_W{1'b0}};
                end else begin
                    req_addr_nxt_s = pc;
                    state_nxt_s    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                ireq_valid_s = 1'b1;
                if (flush) begin
                    pc_stall_s     = 1'b0;
                    if_valid_nxt_s = 1'b0;
                    skid_nxt_s     = {INSTR_W{1'b0}};
                    // A response in the flush cycle retires the request outright
                    if (iresp_data_ok) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end else if (iresp_data_ok) begin
                    if (buf_free(if_valid_r, id_ready)) begin
                        if_valid_nxt_s = 1'b1;
                        if_pc_nxt_s    = req_addr_r;
                        if_instr_nxt_s = iresp_data;
                        pc_stall_s     = 1'b0;
                        state_nxt_s    = ST_IDLE;
                    end else begin
                        // PC stays put so the parked word is delivered exactly once
                        skid_nxt_s  = iresp_data;
                        state_nxt_s = ST_HOLD;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    pc_stall_s     = 1'b0;
                    if_valid_nxt_s = 1'b0;
                    skid_nxt_s     = {INSTR_W{1'b0}};
                    state_nxt_s    = ST_IDLE;
                end else if (id_ready) begin
                    if_valid_nxt_s = 1'b1;
                    if_pc_nxt_s    = req_addr_r;
                    if_instr_nxt_s = skid_r;
                    pc_stall_s     = 1'b0;
                    state_nxt_s    = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                ireq_valid_s = 1'b1;
                if (flush) begin
                    pc_stall_s     = 1'b0;
                    if_valid_nxt_s = 1'b0;
                    skid_nxt_s     = {INSTR_W{1'b0}};
                end else begin
                    pc_stall_s = 1'b1;
                end
                // The stale response closes the old request; nothing is kept
                if (iresp_data_ok) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and buffer registers with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            req_addr_r <= {ADDR_W{1'b0}};
            skid_r     <= {INSTR_W{1'b0}};
            if_valid_r <= 1'b0;
            if_pc_r    <= {ADDR_W{1'b0}};
            if_instr_r <= {INSTR_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            req_addr_r <= req_addr_nxt_s;
            skid_r     <= skid_nxt_s;
            if_valid_r <= if_valid_nxt_s;
            if_pc_r    <= if_pc_nxt_s;
            if_instr_r <= if_instr_nxt_s;
        end
    end

    // While reset is held no request goes out and the PC is frozen
    assign ireq_valid = ireq_valid_s & ~reset;
    assign pc_stall   = pc_stall_s | reset;
    assign ireq_addr  = req_addr_r;
    assign if_valid   = if_valid_r;
    assign if_pc      = if_pc_r;
    assign if_instr   = if_instr_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a behavioural PC register closes the
// loop through pc_stall/flush, and each step checks hand-computed values.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc;
    logic        flush;
    logic        id_ready;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        pc_stall;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;

    logic [63:0] pc_reset_val;
    logic [63:0] target;
    int          deliveries;
    int          vectors    = 0;
    int          miscompares = 0;

    instr_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .flush         (flush),
        .id_ready      (id_ready),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .pc_stall      (pc_stall),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr)
    );

    always #5 clk = ~clk;

    // Behavioural PC register driven by the fetch stage's stall and the redirect
    always @(posedge clk) begin
        if (reset)          pc <= pc_reset_val;
        else if (flush)     pc <= target;
        else if (!pc_stall) pc <= pc + 64'd4;
    end

    // Count delivery pulses (pc_stall low outside reset and flush)
    always @(posedge clk) begin
        if (reset && deliveries < 0) deliveries <= 0;
        else if (!reset && !pc_stall && !flush) deliveries <= deliveries + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        deliveries    = 0;
        pc_reset_val  = 64'h8000_0000;
        target        = 64'h0;
        reset         = 1'b1;
        flush         = 1'b0;
        id_ready      = 1'b0;
        iresp_data_ok = 1'b0;
        iresp_data    = 32'h0;
        tick();
        tick();
        // Reset state
        chk("rst_ireq_valid", ireq_valid, 64'd0);
        chk("rst_pc_stall",   pc_stall,   64'd1);
        chk("rst_if_valid",   if_valid,   64'd0);
        chk("rst_if_pc",      if_pc,      64'd0);
        chk("rst_if_instr",   if_instr,   64'd0);

        // First cycle after reset: IDLE
        reset = 1'b0;
        #1;
        chk("post_rst_ireq_valid", ireq_valid, 64'd0);
        chk("post_rst_pc_stall",   pc_stall,   64'd1);
        tick();
        // WAIT for 0x80000000
        chk("first_ireq_valid", ireq_valid, 64'd1);
        chk("first_ireq_addr",  ireq_addr,  64'h8000_0000);
        chk("first_wait_stall", pc_stall,   64'd1);
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0013;
        #1;
        chk("first_dok_stall", pc_stall, 64'd0);
        tick();
        iresp_data_ok = 1'b0;
        #1;
        chk("first_if_valid", if_valid, 64'd1);
        chk("first_if_pc",    if_pc,    64'h8000_0000);
        chk("first_if_instr", if_instr, 64'h0000_0013);
        chk("first_idle_stall", pc_stall, 64'd1);
        chk("first_pc_next",  pc,       64'h8000_0004);

        // Backpressure: buffer full, id_ready low
        tick();
        chk("bp_ireq_addr", ireq_addr, 64'h8000_0004);
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0040_0093;
        #1;
        chk("bp_full_stall", pc_stall, 64'd1);
        tick();
        iresp_data_ok = 1'b0;
        #1;
        chk("hold_ireq_valid", ireq_valid, 64'd0);
        chk("hold_stall",      pc_stall,   64'd1);
        chk("hold_if_instr",   if_instr,   64'h0000_0013);
        chk("hold_if_pc",      if_pc,      64'h8000_0000);
        chk("hold_pc",         pc,         64'h8000_0004);
        tick();
        chk("hold2_stall", pc_stall, 64'd1);
        id_ready = 1'b1;
        #1;
        chk("hold_release_stall", pc_stall, 64'd0);
        tick();
        chk("skid_if_valid", if_valid, 64'd1);
        chk("skid_if_pc",    if_pc,    64'h8000_0004);
        chk("skid_if_instr", if_instr, 64'h0040_0093);
        chk("skid_pc_next",  pc,       64'h8000_0008);
        // id_ready still high in IDLE: buffer consumed, not reloaded
        tick();
        id_ready = 1'b0;
        #1;
        chk("consume_if_valid", if_valid,   64'd0);
        chk("wait3_ireq_addr",  ireq_addr,  64'h8000_0008);
        chk("deliveries_2",     deliveries, 64'd2);

        // Flush in WAIT without data -> DRAIN
        flush  = 1'b1;
        target = 64'h8000_0100;
        #1;
        chk("flush_wait_stall", pc_stall, 64'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("drain_ireq_valid", ireq_valid, 64'd1);
        chk("drain_ireq_addr",  ireq_addr,  64'h8000_0008);
        chk("drain_stall",      pc_stall,   64'd1);
        chk("drain_pc",         pc,         64'h8000_0100);
        tick();
        tick();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hdead_beef;
        #1;
        chk("drain_dok_stall", pc_stall, 64'd1);
        tick();
        iresp_data_ok = 1'b0;
        #1;
        chk("drained_if_valid",   if_valid,   64'd0);
        chk("drained_ireq_valid", ireq_valid, 64'd0);
        chk("drained_if_instr",   if_instr,   64'h0040_0093);
        tick();
        chk("redirect_ireq_addr", ireq_addr, 64'h8000_0100);

        // Flush together with data_ok in WAIT -> IDLE, data dropped
        flush         = 1'b1;
        target        = 64'h8000_0200;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h1111_1111;
        tick();
        flush         = 1'b0;
        iresp_data_ok = 1'b0;
        #1;
        chk("fdok_ireq_valid", ireq_valid, 64'd0);
        chk("fdok_if_valid",   if_valid,   64'd0);
        chk("fdok_if_instr",   if_instr,   64'h0040_0093);
        tick();
        chk("fdok_next_addr", ireq_addr,  64'h8000_0200);
        chk("fdok_next_valid", ireq_valid, 64'd1);

        // Reset in DRAIN with a late response
        flush  = 1'b1;
        target = 64'h8000_0300;
        tick();
        flush = 1'b0;
        #1;
        chk("drain2_ireq_valid", ireq_valid, 64'd1);
        reset        = 1'b1;
        pc_reset_val = 64'h8000_0400;
        #1;
        chk("rst_drain_ireq_valid", ireq_valid, 64'd0);
        chk("rst_drain_stall",      pc_stall,   64'd1);
        tick();
        reset         = 1'b0;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h2222_2222;
        #1;
        chk("late_ireq_valid", ireq_valid, 64'd0);
        chk("late_stall",      pc_stall,   64'd1);
        tick();
        iresp_data_ok = 1'b0;
        #1;
        chk("late_if_valid",  if_valid,  64'd0);
        chk("late_if_instr",  if_instr,  64'd0);
        chk("late_ireq_addr", ireq_addr, 64'h8000_0400);
        // One clean delivery after the reset
        id_ready      = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0033;
        tick();
        iresp_data_ok = 1'b0;
        id_ready      = 1'b0;
        #1;
        chk("final_if_valid", if_valid,   64'd1);
        chk("final_if_pc",    if_pc,      64'h8000_0400);
        chk("final_if_instr", if_instr,   64'h0000_0033);
        chk("deliveries_3",   deliveries, 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 64: width of pc, bus address and if_pc.
REQ-002 Parameter INSTR_W, default 32: width of instruction data.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 pc  in  ADDR_W  current PC register value; stable while pc_stall=1.
REQ-006 flush  in  1  redirect from EX; PC register loads the target on the same edge.
REQ-007 id_ready  in  1  decode stage accepts the IF/ID buffer this cycle.
REQ-008 iresp_data_ok  in  1  instruction memory returns data this cycle.
REQ-009 iresp_data  in  INSTR_W  returned instruction; valid when iresp_data_ok=1.
REQ-010 ireq_valid  out  1  fetch request outstanding.
REQ-011 ireq_addr  out  ADDR_W  request address.
REQ-012 pc_stall  out  1  drives the PC register stall input; 0 lets PC load its next value.
REQ-013 if_valid  out  1  IF/ID buffer holds an instruction.
REQ-014 if_pc  out  ADDR_W  address of the buffered instruction.
REQ-015 if_instr  out  INSTR_W  buffered instruction.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT, HOLD, DRAIN, with at most one outstanding request.
REQ-017 IDLE: ireq_valid=0, pc_stall=1; next edge latches req_addr<=pc and enters WAIT, unless flush (stays IDLE, pc_stall=0).
REQ-018 WAIT and DRAIN: ireq_valid=1, ireq_addr=req_addr held constant until iresp_data_ok.
REQ-019 WAIT, data_ok, buffer free (if_valid=0 or id_ready=1): load if_pc<=req_addr, if_instr<=iresp_data, if_valid<=1, pc_stall=0, go to IDLE.
REQ-020 WAIT, data_ok, buffer full and id_ready=0: store iresp_data in a skid register, pc_stall=1, go to HOLD.
REQ-021 WAIT, no data_ok: stay, pc_stall=1.
REQ-022 HOLD: ireq_valid=0, pc_stall=1; when id_ready=1, move skid into the buffer (if_pc<=req_addr), pc_stall=0, go to IDLE.
REQ-023 DRAIN: on data_ok, discard data and go to IDLE; pc_stall=1 except in flush cycles.
REQ-024 Flush SHALL take priority over all other events: pc_stall=0, if_valid<=0, skid discarded.
REQ-025 Flush in WAIT with data_ok in the same cycle: drop the data and go to IDLE; without data_ok: go to DRAIN.
REQ-026 Flush in HOLD, DRAIN or IDLE: go to IDLE, DRAIN and IDLE respectively.
REQ-027 Consumption (if_valid and id_ready) without a same-cycle reload SHALL clear if_valid.
REQ-028 Every delivered instruction SHALL correspond to exactly one pc_stall=0 cycle; instructions are never duplicated or skipped except when discarded by flush.

Reset
REQ-029 While reset is high, the next edge SHALL force state=IDLE, if_valid=0, if_pc=0, if_instr=0, req_addr=0 and clear the skid.
REQ-030 Reset in WAIT/DRAIN SHALL abandon the request; a data_ok arriving after reset deasserts while in IDLE SHALL be ignored.
REQ-031 During reset and the first cycle after it: ireq_valid=0, pc_stall=1.

Structure
REQ-032 The FSM state enum (fetch_state_t) SHALL reside in the shared package; ADDR_W and INSTR_W defaults come from the common width defines.
REQ-033 The block SHALL be a single module; no sub-module is required (skid and FSM are inline).

Verification
REQ-034 Reset release with pc=0x80000000: WAIT issues addr 0x80000000; data_ok with data 0x00000013 -> if_valid=1, if_pc=0x80000000, if_instr=0x00000013, pc_stall=0 for exactly one cycle.
REQ-035 Backpressure: buffer holds 0x80000000 with id_ready=0, data_ok for 0x80000004 -> HOLD; raising id_ready delivers 0x80000004 next edge, one pc_stall=0 pulse.
REQ-036 Flush in WAIT without data_ok, then data_ok 3 cycles later -> returned data discarded, if_valid=0, next request addr = redirect target 0x80000100.
REQ-037 Flush in the same cycle as data_ok -> data dropped, IDLE, no DRAIN, if_valid=0.
REQ-038 Reset asserted in DRAIN with a late data_ok -> no if_valid pulse; first request after release uses the current pc.
